// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// forwarding select encodings, register index width and the MULT/DIV timer state type.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Operand source for one EX read port; MEM beats WB and $zero is never forwarded.
    function automatic logic [FWD_W-1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] mem_dst,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_dst,
        input logic             wb_we
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_REG;
        if (mem_we && (mem_dst != REG_ZERO) && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_dst != REG_ZERO) && (wb_dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// MULT/DIV busy timer: IDLE/BUSY FSM with a down-counter loaded on issue.
// Ports: clock, reset (sync, active-high), start (issue in EX), is_div (divide vs
// multiply latency), busy (high for exactly LAT cycles starting the cycle after issue).
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 12,
    parameter int unsigned CNT_W   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a start (even while BUSY) reloads the counter; BUSY ends on the 1->0 step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = MD_BUSY;
            cnt_d   = is_div ? DIV_CNT : MUL_CNT;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    cnt_d = '0;
                end
                MD_BUSY: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = MD_IDLE;
                    end
                end
                default: begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding, load-use bubble,
// HI/LO interlock against the MULT/DIV unit, EX redirect flushes and a stall counter.
// Ports: clock/reset (sync, active-high); ID operand fields and use flags; EX source,
// destination, load, MULT/DIV issue and redirect; MEM/WB destinations and write enables.
// Outputs: fwd_a/fwd_b (combinational selects), stall_if/stall_id/flush_id/flush_ex
// (combinational enables), md_busy, stall_cycles (saturating registered count).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 12,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_hilo,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_md_start,
    input  logic             ex_md_div,
    input  logic             ex_redirect,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_reg_write,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             md_busy,
    output logic [31:0]      stall_cycles
);

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    logic load_use;
    logic hilo_hazard;
    logic hazard;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clock  (clock),
        .reset  (reset),
        .start  (ex_md_start),
        .is_div (ex_md_div),
        .busy   (md_busy)
    );

    // Hazard detection and pipeline enables; a redirect squashes the wrong-path ID
    // instruction, so it cancels any stall raised in the same cycle.
    always_comb begin
        load_use    = 1'b0;
        hilo_hazard = 1'b0;
        hazard      = 1'b0;
        fwd_a       = FWD_REG;
        fwd_b       = FWD_REG;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        if (!reset) begin
            fwd_a = fwd_select(ex_rs, mem_dst, mem_reg_write, wb_dst, wb_reg_write);
            fwd_b = fwd_select(ex_rt, mem_dst, mem_reg_write, wb_dst, wb_reg_write);

            load_use = ex_mem_read && ex_reg_write && (ex_dst != REG_ZERO) &&
                       ((id_use_rs && (id_rs == ex_dst)) ||
                        (id_use_rt && (id_rt == ex_dst)));
            hilo_hazard = id_use_hilo && (md_busy || ex_md_start);
            hazard      = load_use || hilo_hazard;

            if (ex_redirect) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (hazard) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    // Saturating count of cycles the front end was held.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_if && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, registered state updates on the following rising edge.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic        id_use_rs, id_use_rt, id_use_hilo;
    logic        ex_reg_write, ex_mem_read, ex_md_start, ex_md_div, ex_redirect;
    logic        mem_reg_write, wb_reg_write;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall_if, stall_id, flush_id, flush_ex, md_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(12), .CNT_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_use_hilo   (id_use_hilo),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_md_start   (ex_md_start),
        .ex_md_div     (ex_md_div),
        .ex_redirect   (ex_redirect),
        .mem_dst       (mem_dst),
        .mem_reg_write (mem_reg_write),
        .wb_dst        (wb_dst),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .md_busy       (md_busy),
        .stall_cycles  (stall_cycles)
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_hilo = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_dst = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_md_start = 1'b0; ex_md_div = 1'b0; ex_redirect = 1'b0;
        mem_dst = 5'd0; mem_reg_write = 1'b0; wb_dst = 5'd0; wb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        ex_rs = 5'd9; mem_dst = 5'd9; mem_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        id_use_hilo = 1'b1; ex_md_start = 1'b1; ex_md_div = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
        checks++;
        if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {stall_if, stall_id, flush_id, flush_ex});
        end
        @(negedge clock);
        #1;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_fwd();
        // add $t3,$t1,$t1 right behind addi $t1: both operands from MEM
        @(negedge clock);
        idle_inputs();
        ex_rs = 5'd9; ex_rt = 5'd9; mem_dst = 5'd9; mem_reg_write = 1'b1;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_mem_both got %b want 0101", {fwd_a, fwd_b}); end
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL fwd_mem_nostall got %b want 0", stall_if); end
        // producer one slot further back: WB source, rt reads $zero
        @(negedge clock);
        idle_inputs();
        ex_rs = 5'd9; ex_rt = 5'd0; wb_dst = 5'd9; wb_reg_write = 1'b1;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin errors++; $display("FAIL fwd_wb got %b want 1000", {fwd_a, fwd_b}); end
        // MEM and WB both target $t1: MEM wins
        mem_dst = 5'd9; mem_reg_write = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem_priority got %b want 01", fwd_a); end
        // $zero never forwarded
        @(negedge clock);
        idle_inputs();
        ex_rs = 5'd0; ex_rt = 5'd0; mem_dst = 5'd0; mem_reg_write = 1'b1; wb_dst = 5'd0; wb_reg_write = 1'b1;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_zero got %b want 0000", {fwd_a, fwd_b}); end
        // write enable clear: no forward even with matching index
        mem_dst = 5'd7; mem_reg_write = 1'b0; ex_rt = 5'd7;
        #1;
        checks++;
        if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_no_we got %b want 00", fwd_b); end
    endtask

    task automatic test_load_use();
        // lw $t4 in EX, add $t5,$t4,$t3 in ID
        @(negedge clock);
        idle_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd12;
        id_rs = 5'd12; id_use_rs = 1'b1; id_rt = 5'd11; id_use_rt = 1'b1;
        #1;
        checks++;
        if ({stall_if, stall_id, flush_ex, flush_id} !== 4'b1110) begin
            errors++;
            $display("FAIL load_use_stall got %b want 1110", {stall_if, stall_id, flush_ex, flush_id});
        end
        exp_stalls++;
        // bubble behind it; add now in EX with lw in WB
        @(negedge clock);
        idle_inputs();
        ex_rs = 5'd12; ex_rt = 5'd11; wb_dst = 5'd12; wb_reg_write = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL load_use_one_cycle got %b want 0", stall_if); end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin errors++; $display("FAIL load_use_fwd got %b want 1000", {fwd_a, fwd_b}); end
        checks++;
        if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL load_use_count got %0d want %0d", stall_cycles, exp_stalls); end
        // hazard through rt only
        @(negedge clock);
        idle_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd6; id_rt = 5'd6; id_use_rt = 1'b1; id_rs = 5'd6;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL load_use_rt got %b want 1", stall_if); end
        exp_stalls++;
        // same fields but ID does not read them
        @(negedge clock);
        idle_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd6; id_rt = 5'd6; id_rs = 5'd6;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL load_use_unused got %b want 0", stall_if); end
        // load into $zero
        @(negedge clock);
        idle_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL load_use_zero got %b want 0", stall_if); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL load_use_count2 got %0d want %0d", stall_cycles, exp_stalls); end
    endtask

    task automatic test_div_hilo();
        int busy_n;
        int stall_n;
        busy_n = 0;
        stall_n = 0;
        // div in EX, mflo in ID
        @(negedge clock);
        idle_inputs();
        ex_md_start = 1'b1; ex_md_div = 1'b1; id_use_hilo = 1'b1;
        #1;
        checks++;
        if ({stall_if, md_busy} !== 2'b10) begin errors++; $display("FAIL div_issue got %b want 10", {stall_if, md_busy}); end
        if (stall_if) stall_n++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            ex_md_start = 1'b0; ex_md_div = 1'b0;
            #1;
            if (md_busy) busy_n++;
            if (stall_if) stall_n++;
            if (!md_busy && !stall_if) break;
        end
        checks++;
        if (busy_n != 12) begin errors++; $display("FAIL div_busy_len got %0d want 12", busy_n); end
        checks++;
        if (stall_n != 13) begin errors++; $display("FAIL div_stall_len got %0d want 13", stall_n); end
        exp_stalls += 13;
        @(negedge clock);
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL div_count got %0d want %0d", stall_cycles, exp_stalls); end
    endtask

    task automatic test_mult();
        int busy_n;
        busy_n = 0;
        @(negedge clock);
        idle_inputs();
        ex_md_start = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL mult_no_consumer got %b want 0", stall_if); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            ex_md_start = 1'b0;
            #1;
            if (md_busy) busy_n++;
            else break;
        end
        checks++;
        if (busy_n != 4) begin errors++; $display("FAIL mult_busy_len got %0d want 4", busy_n); end
    endtask

    task automatic test_reload();
        int busy_n;
        busy_n = 0;
        @(negedge clock);
        idle_inputs();
        ex_md_start = 1'b1;
        @(negedge clock);
        ex_md_start = 1'b0;
        @(negedge clock);
        ex_md_start = 1'b1; ex_md_div = 1'b1;
        #1;
        checks++;
        if (md_busy !== 1'b1) begin errors++; $display("FAIL reload_busy got %b want 1", md_busy); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            ex_md_start = 1'b0; ex_md_div = 1'b0;
            #1;
            if (md_busy) busy_n++;
            else break;
        end
        checks++;
        if (busy_n != 12) begin errors++; $display("FAIL reload_busy_len got %0d want 12", busy_n); end
    endtask

    task automatic test_redirect();
        int busy_n;
        busy_n = 0;
        // load-use plus taken branch plus mult issue in the same cycle
        @(negedge clock);
        idle_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd12; id_rs = 5'd12; id_use_rs = 1'b1;
        ex_redirect = 1'b1; ex_md_start = 1'b1;
        #1;
        checks++;
        if ({flush_id, flush_ex, stall_if, stall_id} !== 4'b1100) begin
            errors++;
            $display("FAIL redirect_override got %b want 1100", {flush_id, flush_ex, stall_if, stall_id});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (md_busy) busy_n++;
            else break;
        end
        checks++;
        if (busy_n != 4) begin errors++; $display("FAIL redirect_md_accept got %0d want 4", busy_n); end
        checks++;
        if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL redirect_count got %0d want %0d", stall_cycles, exp_stalls); end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clock);
        idle_inputs();
        ex_md_start = 1'b1; ex_md_div = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            idle_inputs();
        end
        // fifth busy cycle: mflo waiting in ID, reset arrives
        @(negedge clock);
        id_use_hilo = 1'b1;
        #1;
        checks++;
        if ({md_busy, stall_if} !== 2'b11) begin errors++; $display("FAIL mid_div_pre got %b want 11", {md_busy, stall_if}); end
        exp_stalls++;
        reset = 1'b1;
        #1;
        checks++;
        if ({stall_if, stall_id, flush_ex} !== 3'b000) begin
            errors++;
            $display("FAIL mid_div_reset_ctrl got %b want 000", {stall_if, stall_id, flush_ex});
        end
        @(negedge clock);
        reset = 1'b0;
        exp_stalls = 0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL mid_div_busy got %b want 0", md_busy); end
        checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL mid_div_count got %0d want 0", stall_cycles); end
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL mid_div_mflo got %b want 0", stall_if); end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fwd();
        test_load_use();
        test_div_hilo();
        test_mult();
        test_reload();
        test_redirect();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Generates operand-forwarding selects for EX and detects load-use hazards, inserting one bubble.
- Applies flushes on control-flow redirects resolved in EX.
- Sequences the multi-cycle MULT/DIV unit with a busy countdown, stalling dependent HI/LO consumers.
- Sits between the pipeline registers and the datapath muxes, and drives the stall/flush enables of the IF/ID and ID/EX registers.

Parameters:
- MUL_LAT, 4, busy cycles after a MULT/MULTU issues in EX (1..15)
- DIV_LAT, 12, busy cycles after a DIV/DIVU issues in EX (1..15)
- CNT_W, 4, width of the busy down-counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_use_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT/DIV
- ex_rs  in  5  rs of the instruction in EX (forwarding)
- ex_rt  in  5  rt of the instruction in EX (forwarding)
- ex_dst  in  5  destination register of EX
- ex_reg_write  in  1  EX writes the register file
- ex_mem_read  in  1  EX is a load
- ex_md_start  in  1  EX issues MULT/DIV this cycle
- ex_md_div  in  1  1 = divide, 0 = multiply (valid with ex_md_start)
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_dst  in  5  destination register of MEM
- mem_reg_write  in  1  MEM writes the register file
- wb_dst  in  5  destination register of WB
- wb_reg_write  in  1  WB writes the register file
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM result, 10 WB result
- fwd_b  out  2  EX operand B select, same encoding
- stall_if  out  1  hold PC
- stall_id  out  1  hold the IF/ID register
- flush_id  out  1  zero the IF/ID register (NOP)
- flush_ex  out  1  load a bubble into ID/EX
- md_busy  out  1  MULT/DIV unit busy
- stall_cycles  out  32  saturating count of stall cycles

Behaviour:
- Reset:
  - md counter = 0, md_busy = 0, stall_cycles = 0.
  - While reset is high, all stall/flush outputs are 0 and fwd_a/fwd_b are 00.
- Forwarding (combinational, no latency):
  - fwd_a = 01 if mem_reg_write and mem_dst != 0 and mem_dst == ex_rs.
  - Otherwise fwd_a = 10 if wb_reg_write and wb_dst != 0 and wb_dst == ex_rs.
  - Otherwise fwd_a = 00. MEM has priority over WB.
  - fwd_b is the same rule using ex_rt.
  - Register $zero is never forwarded.
- Load-use hazard:
  - Condition: ex_mem_read and ex_reg_write and ex_dst != 0, and either (id_use_rs and id_rs == ex_dst) or (id_use_rt and id_rt == ex_dst).
  - Response: stall_if = stall_id = flush_ex = 1 for exactly one cycle.
- HI/LO hazard:
  - Condition: id_use_hilo and (md_busy or ex_md_start).
  - Response: stall_if = stall_id = flush_ex = 1, held until md_busy deasserts.
- Redirect:
  - ex_redirect gives flush_id = flush_ex = 1 and stall_if = stall_id = 0.
  - Redirect overrides any stall in the same cycle, because the stalled ID instruction is wrong-path.
- MULT/DIV sequencing (state IDLE/BUSY, counter-based):
  - IDLE: md_busy = 0. On ex_md_start, load the counter with DIV_LAT (or MUL_LAT) and go to BUSY next edge.
  - BUSY: md_busy = 1. Decrement each cycle; return to IDLE on the edge where the counter reaches 1→0.
  - md_busy is therefore high for exactly LAT cycles, starting the cycle after issue.
  - ex_md_start while BUSY (protocol violation) reloads the counter.
  - ex_md_start coincident with ex_redirect is still accepted (the issuing instruction is in EX, older than the branch target).
- stall_cycles increments by 1 on every edge where stall_if = 1 and reset = 0, and saturates at 0xFFFFFFFF.
- A reset asserted mid-BUSY aborts the operation: the next state is IDLE with counter 0.

Decomposition:
- Shared package/header (alongside ISA.v):
  - forwarding select constants FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10
  - register index width REG_W = 5 and constant REG_ZERO
- Sub-module md_busy_timer holds the IDLE/BUSY FSM and down-counter (inputs start, is_div; output busy).
- All remaining logic is combinational and lives in the top module.

Test Plan:
- addi $t1,$0,3; add $t3,$t1,$t1 back-to-back → fwd_a = fwd_b = 01 in the add's EX cycle; no stall; $t3 = 6.
- addi $t1,$0,3; nop; add $t2,$t1,$0 → fwd_a = 10; then with both MEM and WB targeting $t1, fwd_a = 01 (MEM wins); a dst of $0 gives 00.
- lw $t4,12($0); add $t5,$t4,$t3 → stall_if/stall_id/flush_ex = 1 for exactly 1 cycle; next cycle fwd_a = 10; $t5 = 9; stall_cycles = 1.
- div issued, then mflo immediately behind → md_busy high for 12 cycles; mflo stalled 13 cycles (issue cycle + 12 busy cycles); with MUL_LAT = 4, mult gives a 4-cycle busy pulse.
- Load-use stall and ex_redirect in the same cycle → flush_id = flush_ex = 1, stall_if = 0, stall_cycles unchanged.
- reset pulsed at cycle 5 of a DIV → md_busy = 0 next cycle and stall_cycles = 0; a following mflo is not stalled.
